bt_reg_arbiter: RTL and testbench

BT_REG_ARBITER -- requirements
Module: bt_reg_arbiter

---
 rtl/bt_reg_arbiter.sv | 141 ++++++++++++++
 tb/tb_bt_reg_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bt_reg_arbiter.sv
// bt_reg_arbiter: two-requester round-robin arbiter in front of the Bluetooth
// IP register bus. One access in flight at a time: IDLE grants, BUSY holds the
// bus request until ack, RESP returns a one-cycle response to the winner.
// Optional feature: define BT_ARB_TIMEOUT_EN to abort BUSY after TIMEOUT_CYC
// cycles without bus_ack (response then carries rsp_err=1, rsp_rdata=0).
module bt_reg_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic [1:0]  r_valid,
  output logic [1:0]  r_ready,
  input  logic [1:0]  r_write,
  input  logic [7:0]  r_addr,
  input  logic [63:0] r_wdata,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  input  logic        bus_err
);

  localparam int NUM_REQ = 2;

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 1023) begin : g_bad_param
    $error("TIMEOUT_CYC out of range 2..1023");
  end

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
  } req_t;

  state_t state_q, state_d;
  req_t [NUM_REQ-1:0] req_v;
  req_t        cap_q;
  logic        gnt_q;      // requester owning the current access
  logic        prio_q;     // requester favoured on a tie (0 after reset)
  logic [31:0] rdata_q;
  logic        err_q;
  logic        sel;
  logic        grant;
  logic        misal;
  logic        tmo_hit;

  // Per-requester view of the flattened request buses
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign req_v[i] = {r_write[i], r_addr[i*4 +: 4], r_wdata[i*32 +: 32]};
  end

`ifdef BT_ARB_TIMEOUT_EN
  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYC - 1);
  logic [9:0] cnt_q;

  // BUSY cycle counter, restarted on every grant
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)             cnt_q <= '0;
    else if (state_q == IDLE) cnt_q <= '0;
    else if (state_q == BUSY) cnt_q <= cnt_q + 10'd1;
  end

  assign tmo_hit = (state_q == BUSY) && (cnt_q == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  // Round-robin pick: tie goes to prio_q, otherwise the lone requester
  always_comb begin
    sel = r_valid[1];
    if (r_valid == 2'b11) sel = prio_q;
  end

  assign grant   = ARESETN && (state_q == IDLE) && (|r_valid);
  assign misal   = req_v[sel].addr[1:0] != 2'b00;
  assign r_ready = grant ? (2'b01 << sel) : 2'b00;

  // State register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state; ack only matters while BUSY, ack wins over a same-cycle timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = misal ? RESP : BUSY;
      BUSY:    if (bus_ack || tmo_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the granted request and the response payload
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cap_q   <= '0;
      gnt_q   <= 1'b0;
      prio_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (grant) begin
        cap_q  <= req_v[sel];
        gnt_q  <= sel;
        prio_q <= ~sel;
        if (misal) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end else if (state_q == BUSY) begin
        if (bus_ack) begin
          rdata_q <= cap_q.we ? 32'h0 : bus_rdata;
          err_q   <= bus_err;
        end else if (tmo_hit) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
    end
  end

  // Outputs are gated by state so everything reads 0 outside its phase
  assign bus_req   = (state_q == BUSY);
  assign bus_we    = bus_req & cap_q.we;
  assign bus_addr  = bus_req ? cap_q.addr  : 4'h0;
  assign bus_wdata = bus_req ? cap_q.wdata : 32'h0;

  assign rsp_valid = (state_q == RESP) ? (2'b01 << gnt_q) : 2'b00;
  assign rsp_rdata = (state_q == RESP) ? rdata_q : 32'h0;
  assign rsp_err   = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_bt_reg_arbiter.sv
// Self-checking bench for bt_reg_arbiter: directed scenarios plus a randomized
// transaction stream checked against a transaction-level reference model.
module tb_bt_reg_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [1:0]  r_valid, r_ready, r_write, rsp_valid;
  logic [7:0]  r_addr;
  logic [63:0] r_wdata;
  logic [31:0] rsp_rdata, bus_wdata, bus_rdata;
  logic        rsp_err, bus_req, bus_we, bus_ack, bus_err;
  logic [3:0]  bus_addr;

  int vecs = 0;
  int errs = 0;
  bit prio_m = 1'b0;   // model: requester favoured when both ask

  bt_reg_arbiter #(.TIMEOUT_CYC(8)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .r_valid(r_valid), .r_ready(r_ready), .r_write(r_write),
    .r_addr(r_addr), .r_wdata(r_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .bus_err(bus_err)
  );

  always #5 ACLK = ~ACLK;

  function automatic int pick(input logic [1:0] v);
    if (v == 2'b11) return int'(prio_m);
    return v[1] ? 1 : 0;
  endfunction

  task automatic idle_inputs();
    r_valid = 2'b00; r_write = 2'b00; r_addr = 8'h00; r_wdata = 64'h0;
    bus_rdata = 32'h0; bus_ack = 1'b0; bus_err = 1'b0;
  endtask

  // One full access: grant, optional BUSY phase of dly+1 cycles, then RESP.
  task automatic txn(input logic [1:0] v, input logic [1:0] w, input logic [7:0] a,
                     input logic [63:0] wd, input int dly, input logic [31:0] rd,
                     input logic e, input bit hold, output int g);
    logic [3:0]  ea;
    logic [31:0] ewd, erd;
    logic        ew, mis, ee;
    logic [1:0]  oh;
    @(negedge ACLK);
    r_valid = v; r_write = w; r_addr = a; r_wdata = wd;
    bus_ack = 1'($urandom_range(0, 1));   // ack outside BUSY must be ignored
    bus_rdata = $urandom;
    #1;
    g   = pick(v);
    oh  = (g == 0) ? 2'b01 : 2'b10;
    ea  = a[g*4 +: 4];
    ewd = wd[g*32 +: 32];
    ew  = w[g];
    mis = (ea[1:0] != 2'b00);
    erd = (mis || ew) ? 32'h0 : rd;
    ee  = mis ? 1'b1 : e;
    vecs++;
    if ({r_ready, rsp_valid, rsp_rdata, rsp_err, bus_req} !== {oh, 2'b00, 32'h0, 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL grant: ready=%b rsp_valid=%b rdata=%h err=%b req=%b want ready=%b, rest 0",
               r_ready, rsp_valid, rsp_rdata, rsp_err, bus_req, oh);
    end
    prio_m = (g == 0);
    @(negedge ACLK);
    if (!hold) r_valid = 2'b00;
    r_write = 2'($urandom); r_addr = 8'($urandom); r_wdata = {$urandom, $urandom};
    bus_ack = 1'b0;
    if (!mis) begin
      for (int i = 0; i <= dly; i++) begin
        if (i > 0) @(negedge ACLK);
        bus_ack   = (i == dly);
        bus_rdata = (i == dly) ? rd : $urandom;
        bus_err   = (i == dly) ? e : 1'($urandom);
        #1;
        vecs++;
        if ({r_ready, rsp_valid, bus_req, bus_we, bus_addr, bus_wdata} !== {2'b00, 2'b00, 1'b1, ew, ea, ewd}) begin
          errs++;
          $display("FAIL busy[%0d]: ready=%b rsp=%b req=%b we=%b addr=%h wdata=%h want req=1 we=%b addr=%h wdata=%h",
                   i, r_ready, rsp_valid, bus_req, bus_we, bus_addr, bus_wdata, ew, ea, ewd);
        end
      end
      @(negedge ACLK);
      bus_ack = 1'($urandom_range(0, 1));
      bus_rdata = $urandom;
    end
    #1;
    vecs++;
    if ({rsp_valid, rsp_rdata, rsp_err, bus_req, r_ready} !== {oh, erd, ee, 1'b0, 2'b00}) begin
      errs++;
      $display("FAIL resp: valid=%b rdata=%h err=%b req=%b ready=%b want valid=%b rdata=%h err=%b req=0 ready=0",
               rsp_valid, rsp_rdata, rsp_err, bus_req, r_ready, oh, erd, ee);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    ARESETN = 1'b0;
    r_valid = 2'b11; r_addr = 8'h44; bus_ack = 1'b1;
    repeat (2) @(negedge ACLK);
    #1;
    vecs++;
    if ({r_ready, rsp_valid, rsp_rdata, rsp_err, bus_req, bus_we, bus_addr, bus_wdata} !== '0) begin
      errs++;
      $display("FAIL reset_outputs: ready=%b rsp=%b rdata=%h err=%b req=%b we=%b addr=%h wdata=%h want all 0",
               r_ready, rsp_valid, rsp_rdata, rsp_err, bus_req, bus_we, bus_addr, bus_wdata);
    end
    idle_inputs();
    ARESETN = 1'b1;
    prio_m = 1'b0;
  endtask

  task automatic test_write();
    int g;
    txn(2'b01, 2'b01, 8'h04, {32'hdead_beef, 32'h0000_0001}, 2, 32'h1234_5678, 1'b0, 1'b0, g);
  endtask

  task automatic test_read();
    int g;
    txn(2'b10, 2'b00, 8'hC0, 64'h0, 1, 32'h0000_0004, 1'b0, 1'b0, g);
  endtask

  task automatic test_round_robin();
    int g;
    int exp_g[4] = '{0, 1, 0, 1};
    prio_m = 1'b0;
    // first access from requester 1 alone so the pointer favours 0 next
    txn(2'b10, 2'b00, 8'h80, 64'h0, 0, 32'h5, 1'b0, 1'b0, g);
    for (int k = 0; k < 4; k++) begin
      txn(2'b11, 2'b00, 8'h84, 64'h0, k, 32'h100 + k, 1'b0, 1'b1, g);
      vecs++;
      if (g !== exp_g[k]) begin
        errs++;
        $display("FAIL rr_order[%0d]: got %0d want %0d", k, g, exp_g[k]);
      end
    end
  endtask

  task automatic test_misaligned();
    int g;
    txn(2'b01, 2'b00, 8'h06, 64'h0, 0, 32'h0, 1'b0, 1'b0, g);
    txn(2'b10, 2'b10, 8'h30, 64'hffff_ffff_0000_0000, 0, 32'h0, 1'b0, 1'b0, g);
  endtask

  task automatic test_timeout();
`ifdef BT_ARB_TIMEOUT_EN
    int g;
    int cnt = 0;
    @(negedge ACLK);
    r_valid = 2'b01; r_write = 2'b00; r_addr = 8'h08; bus_ack = 1'b0;
    @(negedge ACLK);
    r_valid = 2'b00;
    #1;
    while (bus_req === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge ACLK);
      #1;
    end
    vecs++;
    if (cnt != 8) begin
      errs++;
      $display("FAIL timeout_len: bus_req high %0d cycles want 8", cnt);
    end
    vecs++;
    if ({rsp_valid, rsp_rdata, rsp_err} !== {2'b01, 32'h0, 1'b1}) begin
      errs++;
      $display("FAIL timeout_resp: valid=%b rdata=%h err=%b want 01 0 1", rsp_valid, rsp_rdata, rsp_err);
    end
    prio_m = 1'b1;
    txn(2'b01, 2'b00, 8'h0C, 64'h0, 3, 32'hCAFE_0001, 1'b0, 1'b0, g);
`endif
  endtask

  task automatic test_reset_busy();
    int g;
    // requester 0 granted, so without reset the pointer would favour 1
    @(negedge ACLK);
    r_valid = 2'b01; r_write = 2'b01; r_addr = 8'h04; r_wdata = 64'h55; bus_ack = 1'b0;
    @(negedge ACLK);
    r_valid = 2'b00;
    #1;
    vecs++;
    if (bus_req !== 1'b1) begin
      errs++;
      $display("FAIL rst_busy_pre: bus_req=%b want 1", bus_req);
    end
    #1 ARESETN = 1'b0;
    #1;
    vecs++;
    if ({bus_req, bus_we, bus_addr, bus_wdata, rsp_valid} !== '0) begin
      errs++;
      $display("FAIL rst_busy_async: req=%b we=%b addr=%h wdata=%h rsp=%b want all 0",
               bus_req, bus_we, bus_addr, bus_wdata, rsp_valid);
    end
    @(negedge ACLK);
    ARESETN = 1'b1;
    prio_m = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge ACLK);
      #1;
      vecs++;
      if ({rsp_valid, bus_req} !== 3'b000) begin
        errs++;
        $display("FAIL rst_busy_norsp[%0d]: rsp=%b req=%b want 0", k, rsp_valid, bus_req);
      end
    end
    txn(2'b11, 2'b00, 8'h48, 64'h0, 0, 32'h77, 1'b0, 1'b0, g);
    vecs++;
    if (g !== 0) begin
      errs++;
      $display("FAIL rst_busy_ptr: got %0d want 0", g);
    end
  endtask

  task automatic test_random();
    int g;
    logic [1:0] v;
    logic [7:0] a;
    for (int k = 0; k < 60; k++) begin
      v = 2'($urandom_range(1, 3));
      a[3:0] = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : {2'($urandom), 2'b00};
      a[7:4] = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : {2'($urandom), 2'b00};
      txn(v, 2'($urandom), a, {$urandom, $urandom}, $urandom_range(0, 5), $urandom,
          1'($urandom), bit'($urandom_range(0, 1)), g);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_misaligned();
    test_timeout();
    test_reset_busy();
    test_random();
    @(negedge ACLK);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
